fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address. Captures the 9-bit instruction the ROM returns combinationally into an IF/ID register, which the decoder consumes through a valid/ready handshake.
- Handles redirects (jumps), BeeF loop-back via a small hardware loop-address stack, stalls, and halt/start control.

Parameters:
- IW, 16, instruction address width; PC wraps modulo 2**IW.
- LSD, 8, loop-stack depth in entries (power of 2, >=2).
- START_ADDR, 0, PC value loaded on reset and on start.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; leaves IDLE and begins fetching at START_ADDR.
- halt_req  input  1  request to stop fetching.
- inst_addr  output  IW  ROM address; equals the PC register.
- inst_in  input  9  instruction returned by the ROM for inst_addr, same cycle.
- if_valid  output  1  IF/ID register holds an instruction.
- if_inst  output  9  captured instruction.
- if_pc  output  IW  address of if_inst.
- if_ready  input  1  decoder accepts if_inst this cycle.
- redirect  input  1  jump request.
- redirect_addr  input  IW  jump target.
- loop_push  input  1  push loop_addr onto the loop stack.
- loop_addr  input  IW  value to push.
- loop_pop  input  1  discard the top of the loop stack.
- loop_back  input  1  jump to the top of the loop stack (peek, no pop).
- halted  output  1  high in IDLE.
- stack_err  output  1  sticky stack-fault flag.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, PC=START_ADDR, if_valid=0, if_inst=0, if_pc=0.
  - Stack empty, stack_err=0, halted=1.
- States: IDLE, RUN, HALTING.
- IDLE:
  - No fetch; if_valid=0.
  - start -> RUN, with PC=START_ADDR, stack cleared, stack_err cleared.
  - All other inputs are ignored.
- RUN, fetch condition: buffer free = (!if_valid || if_ready).
  - When the buffer is free: if_inst<=inst_in, if_pc<=PC, if_valid<=1, PC<=PC+1 (wraps 2**IW-1 -> 0).
  - When the buffer is not free (stall): PC, if_inst and if_pc hold.
- Fetch latency: an instruction appears at if_inst one cycle after its address is on inst_addr. Throughput is 1 per cycle while if_ready=1.
- redirect (RUN only, highest priority):
  - PC<=redirect_addr and if_valid<=0 (flush); no capture that cycle.
  - The fetch of redirect_addr occurs the next cycle.
  - The flushed instruction counts as consumed whether or not if_ready was high.
- loop_back (RUN, no redirect):
  - Stack non-empty: same as redirect, with target = top entry.
  - Stack empty: no redirect, normal fetch proceeds, stack_err<=1.
- Stack operations apply in RUN and HALTING regardless of redirect:
  - push only, not full: push.
  - push only, full: no change, stack_err<=1.
  - pop only, not empty: pop.
  - pop only, empty: no change, stack_err<=1.
  - push+pop together: top replaced by loop_addr; on empty, behave as push.
- loop_back plus stack ops in the same cycle: the jump uses the top entry before the stack update.
- halt_req in RUN:
  - -> HALTING; no new fetch that cycle or after.
  - redirect/loop_back in that cycle still update PC.
- HALTING:
  - Hold if_valid until it is accepted (if_ready) or already 0, then -> IDLE in the same edge.
  - if_valid=0 in IDLE.
  - PC is retained for debug, but start reloads START_ADDR.
- halt_req while IDLE or HALTING: ignored. start outside IDLE: ignored.
- stack_err clears only on reset or start.
- reset_n asserted mid-operation: immediate return to reset values; the in-flight instruction is lost.

Test Plan:
- Reset, start, if_ready=1, ROM[0..3]=9'h011,9'h022,9'h033,9'h044 -> if_inst 011,022,033,044 on consecutive cycles; if_pc 0,1,2,3; halted=0.
- if_ready=0 for 3 cycles after if_pc=1 captured -> inst_addr stays 2, if_inst/if_pc hold 022/1; on release, 033/2 follows next cycle.
- redirect=1, redirect_addr=16'h0100 while if_valid=1 -> if_valid=0 next cycle; following cycle if_pc=16'h0100.
- Push 16'h0010, push 16'h0020, loop_back -> next fetch if_pc=16'h0020; pop, loop_back -> if_pc=16'h0010; pop, loop_back on empty -> no jump, stack_err=1 until next start.
- LSD=8: nine pushes -> stack_err=1 on 9th, top still 8th value; push+pop in the same cycle -> top replaced, depth unchanged.
- halt_req with if_valid=1 and if_ready=0 -> HALTING, if_valid held; if_ready=1 -> IDLE, halted=1. PC at 16'hFFFF, fetch -> next inst_addr=0 (wrap). reset_n low mid-RUN -> outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures the ROM word into an IF/ID
// register with valid/ready, and supports redirects, a hardware loop stack and halt/start.
module fetch_unit #(
  parameter int IW         = 16,
  parameter int LSD        = 8,
  parameter int START_ADDR = 0
) (
  input  logic          CLK,
  input  logic          reset_n,
  input  logic          start,
  input  logic          halt_req,
  output logic [IW-1:0] inst_addr,
  input  logic [8:0]    inst_in,
  output logic          if_valid,
  output logic [8:0]    if_inst,
  output logic [IW-1:0] if_pc,
  input  logic          if_ready,
  input  logic          redirect,
  input  logic [IW-1:0] redirect_addr,
  input  logic          loop_push,
  input  logic [IW-1:0] loop_addr,
  input  logic          loop_pop,
  input  logic          loop_back,
  output logic          halted,
  output logic          stack_err
);
  localparam int AW = $clog2(LSD);
  localparam logic [IW-1:0] START_PC = IW'(START_ADDR);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(LSD);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, HALTING} state_t;

  state_t        stateReg, stateNext;
  logic [IW-1:0] pcReg, pcNext;
  logic [IW-1:0] ifPcReg, ifPcNext;
  logic [8:0]    instReg, instNext;
  logic          validReg, validNext;
  logic          errReg, errNext;
  logic [AW:0]   depthReg, depthNext;

  logic [IW-1:0] stackMem [LSD];
  logic          memWe;
  logic [AW-1:0] memWaddr;
  logic [AW-1:0] topIdx;
  logic [IW-1:0] topEntry;
  logic          stackEmpty, stackFull, bufFree, jumpTaken;
  logic [IW-1:0] jumpTarget;

  assign stackEmpty = (depthReg == '0);
  assign stackFull  = (depthReg == FULL_CNT);
  assign topIdx     = AW'(depthReg - ONE_CNT);
  assign topEntry   = stackMem[topIdx];
  assign bufFree    = !validReg || if_ready;

  // Jump target is taken from the pre-update top so same-cycle push/pop cannot affect it.
  always_comb begin
    jumpTaken  = 1'b0;
    jumpTarget = redirect_addr;
    if (redirect) begin
      jumpTaken = 1'b1;
    end else if (loop_back && !stackEmpty) begin
      jumpTaken  = 1'b1;
      jumpTarget = topEntry;
    end
  end

  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    ifPcNext  = ifPcReg;
    instNext  = instReg;
    validNext = validReg;
    errNext   = errReg;
    depthNext = depthReg;
    memWe     = 1'b0;
    memWaddr  = '0;

    case (stateReg)
      IDLE: begin
        validNext = 1'b0;
        if (start) begin
          stateNext = RUN;
          pcNext    = START_PC;
          depthNext = '0;
          errNext   = 1'b0;
        end
      end
      RUN: begin
        if (!redirect && loop_back && stackEmpty) errNext = 1'b1;
        if (jumpTaken) begin
          pcNext    = jumpTarget;
          validNext = 1'b0;
        end else if (!halt_req && bufFree) begin
          instNext  = inst_in;
          ifPcNext  = pcReg;
          validNext = 1'b1;
          pcNext    = pcReg + IW'(1);
        end else if (halt_req && if_ready) begin
          validNext = 1'b0;
        end
        if (halt_req) stateNext = HALTING;
      end
      HALTING: begin
        if (bufFree) begin
          validNext = 1'b0;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    // Push+pop on a non-empty stack overwrites the top; on empty it degrades to a push.
    if (stateReg == RUN || stateReg == HALTING) begin
      if (loop_push && loop_pop && !stackEmpty) begin
        memWe    = 1'b1;
        memWaddr = topIdx;
      end else if (loop_push) begin
        if (stackFull) begin
          errNext = 1'b1;
        end else begin
          memWe     = 1'b1;
          memWaddr  = depthReg[AW-1:0];
          depthNext = depthReg + ONE_CNT;
        end
      end else if (loop_pop) begin
        if (stackEmpty) errNext = 1'b1;
        else            depthNext = depthReg - ONE_CNT;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (memWe) stackMem[memWaddr] <= loop_addr;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      stateReg <= IDLE;
      pcReg    <= START_PC;
      ifPcReg  <= '0;
      instReg  <= '0;
      validReg <= 1'b0;
      errReg   <= 1'b0;
      depthReg <= '0;
    end else begin
      stateReg <= stateNext;
      pcReg    <= pcNext;
      ifPcReg  <= ifPcNext;
      instReg  <= instNext;
      validReg <= validNext;
      errReg   <= errNext;
      depthReg <= depthNext;
    end
  end

  assign inst_addr = pcReg;
  assign if_valid  = validReg;
  assign if_inst   = instReg;
  assign if_pc     = ifPcReg;
  assign halted    = (stateReg == IDLE);
  assign stack_err = errReg;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        reset_n, start, halt_req, if_ready, redirect;
  logic        loop_push, loop_pop, loop_back;
  logic [15:0] inst_addr, if_pc, redirect_addr, loop_addr;
  logic [8:0]  inst_in, if_inst;
  logic        if_valid, halted, stack_err;

  int nChecks = 0;
  int nPass   = 0;

  // Behavioural model state (mode: 0 idle, 1 running, 2 draining)
  int          mMode;
  logic [15:0] mPc, mIfPc;
  logic [8:0]  mInst;
  logic        mValid, mErr;
  logic [15:0] stk[$];

  fetch_unit #(.IW(16), .LSD(8), .START_ADDR(0)) dut (
    .CLK(CLK), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .inst_addr(inst_addr), .inst_in(inst_in), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .if_ready(if_ready),
    .redirect(redirect), .redirect_addr(redirect_addr),
    .loop_push(loop_push), .loop_addr(loop_addr), .loop_pop(loop_pop),
    .loop_back(loop_back), .halted(halted), .stack_err(stack_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] rom(input logic [15:0] a);
    if (a < 16'd4) return 9'((a + 16'd1) * 16'h11);
    return 9'(a ^ (a >> 7)) ^ 9'h15A;
  endfunction

  assign inst_in = rom(inst_addr);

  task automatic clearInputs();
    start = 0; halt_req = 0; if_ready = 0; redirect = 0; redirect_addr = 0;
    loop_push = 0; loop_pop = 0; loop_back = 0; loop_addr = 0;
  endtask

  task automatic modelReset();
    mMode = 0; mPc = 0; mIfPc = 0; mInst = 0; mValid = 0; mErr = 0;
    stk.delete();
  endtask

  // Applies the spec rules for one clock edge using the inputs present at that edge.
  task automatic modelStep();
    bit          emptyBefore, jump;
    logic [15:0] topBefore, tgt;
    int          modeBefore;
    emptyBefore = (stk.size() == 0);
    topBefore   = emptyBefore ? 16'h0 : stk[$];
    modeBefore  = mMode;
    jump = 0; tgt = 0;
    case (mMode)
      0: if (start) begin mMode = 1; mPc = 0; stk.delete(); mErr = 0; end
      1: begin
        if (redirect) begin jump = 1; tgt = redirect_addr; end
        else if (loop_back) begin
          if (emptyBefore) mErr = 1;
          else begin jump = 1; tgt = topBefore; end
        end
        if (jump) begin mPc = tgt; mValid = 0; end
        else if (!halt_req && (!mValid || if_ready)) begin
          mInst = rom(mPc); mIfPc = mPc; mValid = 1; mPc = mPc + 16'd1;
        end else if (halt_req && if_ready) mValid = 0;
        if (halt_req) mMode = 2;
      end
      default: if (!mValid || if_ready) begin mValid = 0; mMode = 0; end
    endcase
    if (modeBefore != 0) begin
      if (loop_push && loop_pop) begin
        if (emptyBefore) stk.push_back(loop_addr);
        else stk[stk.size()-1] = loop_addr;
      end else if (loop_push) begin
        if (stk.size() == 8) mErr = 1;
        else stk.push_back(loop_addr);
      end else if (loop_pop) begin
        if (emptyBefore) mErr = 1;
        else void'(stk.pop_back());
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    modelStep();
    #1;
  endtask

  task automatic resetDut();
    clearInputs();
    reset_n = 0;
    repeat (2) @(posedge CLK);
    #1 reset_n = 1;
    modelReset();
  endtask

  task automatic restart();
    resetDut();
    start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    resetDut();
    nChecks++; if (halted !== 1'b1) $display("FAIL reset_halted got=%b exp=1", halted); else nPass++;
    nChecks++; if (if_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", if_valid); else nPass++;
    nChecks++; if (inst_addr !== 16'h0) $display("FAIL reset_addr got=%h exp=0000", inst_addr); else nPass++;
    nChecks++; if ({if_inst, if_pc, stack_err} !== 26'h0)
      $display("FAIL reset_regs got inst=%h pc=%h err=%b exp all zero", if_inst, if_pc, stack_err); else nPass++;
  endtask

  task automatic test_fetch();
    restart();
    if_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      nChecks++;
      if (if_inst !== 9'((k + 1) * 17) || if_pc !== 16'(k) || if_valid !== 1'b1 || halted !== 1'b0)
        $display("FAIL fetch_seq%0d got inst=%h pc=%h v=%b h=%b exp inst=%h pc=%h v=1 h=0",
                 k, if_inst, if_pc, if_valid, halted, 9'((k + 1) * 17), 16'(k));
      else nPass++;
    end
  endtask

  task automatic test_stall();
    restart();
    if_ready = 1; tick(); tick();
    if_ready = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nChecks++;
      if (inst_addr !== 16'd2 || if_inst !== 9'h022 || if_pc !== 16'd1)
        $display("FAIL stall_hold%0d got addr=%h inst=%h pc=%h exp addr=0002 inst=022 pc=0001",
                 k, inst_addr, if_inst, if_pc);
      else nPass++;
    end
    if_ready = 1; tick();
    nChecks++; if (if_inst !== 9'h033 || if_pc !== 16'd2)
      $display("FAIL stall_release got inst=%h pc=%h exp inst=033 pc=0002", if_inst, if_pc); else nPass++;
  endtask

  task automatic test_redirect();
    redirect = 1; redirect_addr = 16'h0100; tick(); redirect = 0;
    nChecks++; if (if_valid !== 1'b0 || inst_addr !== 16'h0100)
      $display("FAIL redirect_flush got v=%b addr=%h exp v=0 addr=0100", if_valid, inst_addr); else nPass++;
    tick();
    nChecks++; if (if_valid !== 1'b1 || if_pc !== 16'h0100 || if_inst !== rom(16'h0100))
      $display("FAIL redirect_fetch got v=%b pc=%h inst=%h exp v=1 pc=0100 inst=%h",
               if_valid, if_pc, if_inst, rom(16'h0100)); else nPass++;
  endtask

  task automatic test_loop_stack();
    logic [15:0] prev;
    loop_push = 1; loop_addr = 16'h0010; tick();
    loop_addr = 16'h0020; tick(); loop_push = 0;
    loop_back = 1; tick(); loop_back = 0;
    nChecks++; if (if_valid !== 1'b0 || inst_addr !== 16'h0020)
      $display("FAIL loop_jump1 got v=%b addr=%h exp v=0 addr=0020", if_valid, inst_addr); else nPass++;
    tick();
    nChecks++; if (if_pc !== 16'h0020) $display("FAIL loop_fetch1 got=%h exp=0020", if_pc); else nPass++;
    loop_pop = 1; tick(); loop_pop = 0;
    loop_back = 1; tick(); loop_back = 0; tick();
    nChecks++; if (if_pc !== 16'h0010) $display("FAIL loop_fetch2 got=%h exp=0010", if_pc); else nPass++;
    loop_pop = 1; tick(); loop_pop = 0;
    prev = inst_addr;
    loop_back = 1; tick(); loop_back = 0;
    nChecks++; if (stack_err !== 1'b1 || if_valid !== 1'b1 || if_pc !== prev || inst_addr !== prev + 16'd1)
      $display("FAIL loop_empty got err=%b v=%b pc=%h addr=%h exp err=1 v=1 pc=%h addr=%h",
               stack_err, if_valid, if_pc, inst_addr, prev, prev + 16'd1); else nPass++;
    tick(); tick();
    nChecks++; if (stack_err !== 1'b1) $display("FAIL loop_err_sticky got=%b exp=1", stack_err); else nPass++;
  endtask

  task automatic test_overflow();
    restart();
    if_ready = 1;
    loop_push = 1;
    for (int i = 0; i < 8; i++) begin loop_addr = 16'h0200 + 16'(i); tick(); end
    nChecks++; if (stack_err !== 1'b0) $display("FAIL ovf_full_ok got=%b exp=0", stack_err); else nPass++;
    loop_addr = 16'h02FF; tick(); loop_push = 0;
    nChecks++; if (stack_err !== 1'b1) $display("FAIL ovf_err got=%b exp=1", stack_err); else nPass++;
    loop_back = 1; tick(); loop_back = 0; tick();
    nChecks++; if (if_pc !== 16'h0207) $display("FAIL ovf_top got=%h exp=0207", if_pc); else nPass++;
    loop_push = 1; loop_pop = 1; loop_addr = 16'h0333; tick(); loop_push = 0; loop_pop = 0;
    loop_back = 1; tick(); loop_back = 0; tick();
    nChecks++; if (if_pc !== 16'h0333) $display("FAIL ovf_replace got=%h exp=0333", if_pc); else nPass++;
    loop_pop = 1; repeat (7) tick(); loop_pop = 0;
    loop_back = 1; tick(); loop_back = 0; tick();
    nChecks++; if (if_pc !== 16'h0200) $display("FAIL ovf_depth got=%h exp=0200", if_pc); else nPass++;
  endtask

  task automatic test_halt();
    restart();
    if_ready = 1; tick(); tick();
    loop_back = 1; tick(); loop_back = 0;
    nChecks++; if (stack_err !== 1'b1) $display("FAIL halt_pre_err got=%b exp=1", stack_err); else nPass++;
    if_ready = 0; halt_req = 1; tick(); halt_req = 0;
    nChecks++; if (halted !== 1'b0 || if_valid !== 1'b1)
      $display("FAIL halt_enter got h=%b v=%b exp h=0 v=1", halted, if_valid); else nPass++;
    tick();
    nChecks++; if (halted !== 1'b0 || if_valid !== 1'b1)
      $display("FAIL halt_hold got h=%b v=%b exp h=0 v=1", halted, if_valid); else nPass++;
    if_ready = 1; tick();
    nChecks++; if (halted !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL halt_idle got h=%b v=%b exp h=1 v=0", halted, if_valid); else nPass++;
    start = 1; tick(); start = 0;
    nChecks++; if (stack_err !== 1'b0 || inst_addr !== 16'h0 || halted !== 1'b0)
      $display("FAIL halt_restart got err=%b addr=%h h=%b exp err=0 addr=0000 h=0",
               stack_err, inst_addr, halted); else nPass++;
  endtask

  task automatic test_wrap();
    restart();
    if_ready = 1;
    redirect = 1; redirect_addr = 16'hFFFF; tick(); redirect = 0;
    tick();
    nChecks++; if (if_pc !== 16'hFFFF || inst_addr !== 16'h0000)
      $display("FAIL wrap_edge got pc=%h addr=%h exp pc=ffff addr=0000", if_pc, inst_addr); else nPass++;
    tick();
    nChecks++; if (if_pc !== 16'h0000 || if_inst !== 9'h011)
      $display("FAIL wrap_fetch got pc=%h inst=%h exp pc=0000 inst=011", if_pc, if_inst); else nPass++;
  endtask

  task automatic test_async_reset();
    restart();
    if_ready = 1; loop_push = 1; loop_addr = 16'h0055; tick(); loop_push = 0; tick(); tick();
    #2 reset_n = 0;
    #1;
    nChecks++; if (halted !== 1'b1 || if_valid !== 1'b0 || inst_addr !== 16'h0 || if_pc !== 16'h0 ||
                   if_inst !== 9'h0 || stack_err !== 1'b0)
      $display("FAIL async_reset got h=%b v=%b addr=%h pc=%h inst=%h err=%b exp h=1 v=0 rest zero",
               halted, if_valid, inst_addr, if_pc, if_inst, stack_err); else nPass++;
    @(negedge CLK) reset_n = 1;
    clearInputs();
    modelReset();
    tick();
    nChecks++; if (halted !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL async_stay_idle got h=%b v=%b exp h=1 v=0", halted, if_valid); else nPass++;
  endtask

  task automatic test_random();
    restart();
    for (int c = 0; c < 400; c++) begin
      start         = ($urandom_range(0, 3) == 0);
      halt_req      = ($urandom_range(0, 29) == 0);
      if_ready      = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 9) == 0);
      redirect_addr = 16'($urandom);
      loop_back     = ($urandom_range(0, 7) == 0);
      loop_push     = ($urandom_range(0, 4) == 0);
      loop_pop      = ($urandom_range(0, 5) == 0);
      loop_addr     = 16'($urandom_range(0, 16'hFFFF));
      tick();
      nChecks++;
      if (inst_addr !== mPc || if_valid !== mValid || if_inst !== mInst || if_pc !== mIfPc ||
          halted !== (mMode == 0) || stack_err !== mErr)
        $display("FAIL random_c%0d got addr=%h v=%b inst=%h pc=%h h=%b err=%b exp addr=%h v=%b inst=%h pc=%h h=%b err=%b",
                 c, inst_addr, if_valid, if_inst, if_pc, halted, stack_err,
                 mPc, mValid, mInst, mIfPc, (mMode == 0), mErr);
      else nPass++;
    end
    clearInputs();
  endtask

  initial begin
    clearInputs();
    reset_n = 0;
    modelReset();
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_loop_stack();
    test_overflow();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
